// File: rtl/router_pkt_register_pkg.sv
// Shared types and constants for the router packet register stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   state_t      load FSM encoding
//   PARITY_XOR / PARITY_SUM   accumulator mode selectors
//   clog2()      ceiling log2 used to size the destination field
package router_pkt_register_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LFD   = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4,
    DROP  = 3'd5
  } state_t;

  localparam int PARITY_XOR = 0;
  localparam int PARITY_SUM = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/router_pkt_register_if.sv
// Word stream between router stages: a valid-qualified data word plus a stall
// flag returned by the receiver.
// Latency: n/a (wires only). Backpressure: receiver raises stall.
//   valid  word qualifier (pkt_valid on the input side, write strobe on the FIFO side)
//   data   DATA_W-bit word
//   stall  receiver cannot take a word (busy on the input side, fifo_full on the FIFO side)
interface router_pkt_register_if #(parameter int DATA_W = 8);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              stall;

  modport master (output valid, output data, input  stall);
  modport slave  (input  valid, input  data, output stall);
endinterface

// File: rtl/router_pkt_register_parity_acc.sv
// Packet parity accumulator: XOR or modular sum of header and payload words.
// Latency: result visible one cycle after load/update.
// Backpressure: none; the caller only pulses update for accepted words.
//   clr     zero the accumulator
//   load    start a new packet with din (the header)
//   update  fold din into the running value
//   acc     current accumulated parity
module router_parity_acc
  import router_pkt_register_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = PARITY_XOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              update,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= din;
    end else if (update) begin
      if (PARITY_MODE == PARITY_SUM) acc <= acc + din;
      else                           acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/router_pkt_register.sv
// Router packet register: takes header+payload from the input port, forwards them to the
// selected FIFO, checks trailing parity and payload length, discards packets to bad ports.
// Latency: header one cycle after accept, payload words one cycle; backpressure: a word that
// meets a full FIFO is parked in a hold register and in_if.stall (busy) holds the upstream.
//   clk, rst        clock, asynchronous active-low reset
//   in_if (slave)   valid=pkt_valid, data=d_in, stall=busy
//   out_if (master) valid=dout_valid, data=dout, stall=fifo_full
//   dest/dest_valid destination of current packet and its accept pulse
//   parity_done, err, len_err, low_pkt_valid, drop   packet status
module router_pkt_register
  import router_pkt_register_pkg::*;
#(
  parameter int  DATA_W      = 8,
  parameter int  NUM_PORTS   = 3,
  parameter int  PARITY_MODE = PARITY_XOR,
  localparam int ADDR_W      = clog2(NUM_PORTS),
  localparam int LEN_W       = DATA_W - ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  router_pkt_register_if.slave   in_if,
  router_pkt_register_if.master  out_if,
  output logic [ADDR_W-1:0]      dest,
  output logic                   dest_valid,
  output logic                   parity_done,
  output logic                   err,
  output logic                   len_err,
  output logic                   low_pkt_valid,
  output logic                   drop
);

  localparam logic [ADDR_W:0] PORT_LIM = (ADDR_W+1)'(NUM_PORTS);
  localparam logic [LEN_W:0]  CNT_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0]  CNT_MAX  = {(LEN_W+1){1'b1}};

  state_t            state;
  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] par;
  logic [LEN_W:0]    cnt;
  logic [DATA_W-1:0] acc;

  logic              hdr_ok;
  logic              acc_clr;
  logic              acc_load;
  logic              acc_update;
  logic [LEN_W-1:0]  hdr_len;

  assign hdr_ok  = {1'b0, in_if.data[ADDR_W-1:0]} < PORT_LIM;
  assign hdr_len = hdr[DATA_W-1:ADDR_W];

  // Words are folded in as they are accepted, including the one parked in
  // HOLD, so the parity never depends on when the FIFO drains.
  assign acc_load   = (state == IDLE) && in_if.valid && hdr_ok;
  assign acc_clr    = (state == IDLE) && in_if.valid && !hdr_ok;
  assign acc_update = (state == LOAD) && in_if.valid;

  // LOAD never stalls: a word that meets a full FIFO goes to the hold register.
  assign in_if.stall = (state == LFD) || (state == HOLD) || (state == CHECK);

  router_parity_acc #(
    .DATA_W      (DATA_W),
    .PARITY_MODE (PARITY_MODE)
  ) u_parity_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .load   (acc_load),
    .update (acc_update),
    .din    (in_if.data),
    .acc    (acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      hdr           <= '0;
      hold          <= '0;
      par           <= '0;
      cnt           <= '0;
      out_if.data   <= '0;
      out_if.valid  <= 1'b0;
      dest          <= '0;
      dest_valid    <= 1'b0;
      parity_done   <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
      low_pkt_valid <= 1'b0;
      drop          <= 1'b0;
    end else begin
      out_if.valid <= 1'b0;
      dest_valid   <= 1'b0;
      drop         <= 1'b0;

      case (state)
        IDLE: begin
          if (in_if.valid) begin
            if (hdr_ok) begin
              hdr           <= in_if.data;
              cnt           <= '0;
              dest          <= in_if.data[ADDR_W-1:0];
              dest_valid    <= 1'b1;
              parity_done   <= 1'b0;
              err           <= 1'b0;
              len_err       <= 1'b0;
              low_pkt_valid <= 1'b0;
              state         <= LFD;
            end else begin
              // Status of the previous packet stays visible while we discard.
              state <= DROP;
            end
          end
        end

        LFD: begin
          if (!out_if.stall) begin
            out_if.data  <= hdr;
            out_if.valid <= 1'b1;
            state        <= LOAD;
          end
        end

        LOAD: begin
          if (in_if.valid) begin
            // Saturation keeps an oversize packet from wrapping back to a legal count.
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
            if (out_if.stall) begin
              hold  <= in_if.data;
              state <= HOLD;
            end else begin
              out_if.data  <= in_if.data;
              out_if.valid <= 1'b1;
            end
          end else begin
            // Parity word is checked locally and never written to the FIFO.
            par           <= in_if.data;
            low_pkt_valid <= 1'b1;
            state         <= CHECK;
          end
        end

        HOLD: begin
          if (!out_if.stall) begin
            out_if.data  <= hold;
            out_if.valid <= 1'b1;
            state        <= LOAD;
          end
        end

        CHECK: begin
          parity_done <= 1'b1;
          err         <= (acc != par);
          len_err     <= (cnt != {1'b0, hdr_len});
          state       <= IDLE;
        end

        DROP: begin
          // The first idle cycle carries the discarded packet's parity word.
          if (!in_if.valid) begin
            drop  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
